// File: rtl/bus_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_reg_pkg
//  Description : Shared definitions for the bus register bank: operation
//                encodings and default bank geometry.
//  Contents    : op_t         - 3-bit operation code applied on a write
//                DEFAULT_WIDTH - default register/bus width
//                DEFAULT_DEPTH - default number of registers
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_reg_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_INC  = 3'b001,
    OP_DEC  = 3'b010,
    OP_SHL  = 3'b011,
    OP_SHR  = 3'b100,
    OP_CLR  = 3'b101,
    OP_ADD  = 3'b110,
    OP_SUB  = 3'b111
  } op_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

endpackage : bus_reg_pkg
`default_nettype wire

// File: rtl/bus_reg_alu.sv
`default_nettype none
// ============================================================================
//  Module      : bus_reg_alu
//  Description : Combinational in-place operation unit for the register bank.
//                Produces the new register value and its carry/zero flags.
//  Ports       : r_i      [WIDTH] current value of the destination register
//                b_i      [WIDTH] bus operand
//                op_i     [3]     operation code (op_t)
//                result_o [WIDTH] value to be written back
//                carry_o  [1]     carry-out / borrow / shifted-out bit
//                zero_o   [1]     result_o == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_reg_alu
  import bus_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_t              op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o
);

  // One bit wider than the operands so the top bit carries the carry-out
  // on addition and the borrow on subtraction (wraps to 1 when r < b).
  logic [WIDTH:0] w_ext;

  always_comb begin
    w_ext    = '0;
    result_o = r_i;
    carry_o  = 1'b0;
    case (op_i)
      OP_LOAD: begin
        result_o = b_i;
      end
      OP_INC: begin
        w_ext    = {1'b0, r_i} + (WIDTH+1)'(1);
        result_o = w_ext[WIDTH-1:0];
        carry_o  = w_ext[WIDTH];
      end
      OP_DEC: begin
        w_ext    = {1'b0, r_i} - (WIDTH+1)'(1);
        result_o = w_ext[WIDTH-1:0];
        carry_o  = w_ext[WIDTH];
      end
      OP_SHL: begin
        result_o = {r_i[WIDTH-2:0], 1'b0};
        carry_o  = r_i[WIDTH-1];
      end
      OP_SHR: begin
        result_o = {1'b0, r_i[WIDTH-1:1]};
        carry_o  = r_i[0];
      end
      OP_CLR: begin
        result_o = '0;
      end
      OP_ADD: begin
        w_ext    = {1'b0, r_i} + {1'b0, b_i};
        result_o = w_ext[WIDTH-1:0];
        carry_o  = w_ext[WIDTH];
      end
      OP_SUB: begin
        w_ext    = {1'b0, r_i} - {1'b0, b_i};
        result_o = w_ext[WIDTH-1:0];
        carry_o  = w_ext[WIDTH];
      end
      default: begin
        result_o = r_i;
      end
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule : bus_reg_alu
`default_nettype wire

// File: rtl/bus_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : bus_reg_bank
//  Description : Bank of DEPTH registers of WIDTH bits sharing one input bus
//                and one output bus. Each accepted write applies an in-place
//                operation to the selected register and updates carry/zero.
//  Ports       : clk     [1]     rising-edge clock
//                rst_n   [1]     asynchronous active-low reset
//                n_load  [1]     active-low write strobe
//                wr_sel  [SEL_W] destination register index
//                op      [3]     operation code (see bus_reg_pkg::op_t)
//                bus_in  [WIDTH] bus operand
//                n_out   [1]     active-low output enable
//                rd_sel  [SEL_W] read-port register index
//                bus_out [WIDTH] reg[rd_sel] when n_out=0, else 0
//                bus_oe  [1]     pad output enable (~n_out)
//                value   [WIDTH] reg[rd_sel], ungated
//                carry   [1]     carry/borrow flag of last accepted write
//                zero    [1]     zero flag of last accepted write
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_reg_bank
  import bus_reg_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             n_load,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             n_out,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             zero
);

  // Every index an SEL_W-bit select can express.
  localparam int SLOTS = 2**SEL_W;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             carry_q, carry_d;
  logic             zero_q,  zero_d;

  logic [WIDTH-1:0] w_slot [SLOTS];
  logic             w_wr_valid;
  logic [WIDTH-1:0] w_operand;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_zero;

  // Pad the bank out to a full power-of-two table so that any select
  // value indexes something; unimplemented slots read as zero.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi < DEPTH) begin : g_real
      assign w_slot[gi] = regs_q[gi];
    end else begin : g_pad
      assign w_slot[gi] = '0;
    end
  end

  // Writes to unimplemented indices are dropped entirely, flags included.
  if (DEPTH == SLOTS) begin : g_wr_full
    assign w_wr_valid = 1'b1;
  end else begin : g_wr_range
    assign w_wr_valid = (wr_sel < SEL_W'(DEPTH));
  end

  assign w_operand = w_slot[wr_sel];

  bus_reg_alu #(
    .WIDTH    (WIDTH)
  ) u_alu (
    .r_i      (w_operand),
    .b_i      (bus_in),
    .op_i     (op_t'(op)),
    .result_o (w_result),
    .carry_o  (w_carry),
    .zero_o   (w_zero)
  );

  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (!n_load && w_wr_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel == SEL_W'(i)) begin
          regs_d[i] = w_result;
        end
      end
      carry_d = w_carry;
      zero_d  = w_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Read port is purely combinational from stored state, so a read of the
  // register being written shows the pre-write value until the edge.
  assign value   = w_slot[rd_sel];
  assign bus_out = n_out ? '0 : value;
  assign bus_oe  = ~n_out;
  assign carry   = carry_q;
  assign zero    = zero_q;

endmodule : bus_reg_bank
`default_nettype wire

// File: tb/tb_bus_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_reg_bank
//  Description : Self-checking bench for bus_reg_bank. Instance A uses the
//                default 8-bit x 4 geometry; instance B uses 4-bit x 3 to
//                exercise unimplemented register indices.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_reg_bank;

  logic clk;
  logic rst_n;

  // Instance A (WIDTH=8, DEPTH=4)
  logic       a_n_load, a_n_out, a_bus_oe, a_carry, a_zero;
  logic [1:0] a_wr_sel, a_rd_sel;
  logic [2:0] a_op;
  logic [7:0] a_bus_in, a_bus_out, a_value;

  // Instance B (WIDTH=4, DEPTH=3)
  logic       b_n_load, b_n_out, b_bus_oe, b_carry, b_zero;
  logic [1:0] b_wr_sel, b_rd_sel;
  logic [2:0] b_op;
  logic [3:0] b_bus_in, b_bus_out, b_value;

  bus_reg_bank #(.WIDTH(8), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .n_load(a_n_load), .wr_sel(a_wr_sel), .op(a_op),
    .bus_in(a_bus_in), .n_out(a_n_out), .rd_sel(a_rd_sel), .bus_out(a_bus_out),
    .bus_oe(a_bus_oe), .value(a_value), .carry(a_carry), .zero(a_zero)
  );

  bus_reg_bank #(.WIDTH(4), .DEPTH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .n_load(b_n_load), .wr_sel(b_wr_sel), .op(b_op),
    .bus_in(b_bus_in), .n_out(b_n_out), .rd_sel(b_rd_sel), .bus_out(b_bus_out),
    .bus_oe(b_bus_oe), .value(b_value), .carry(b_carry), .zero(b_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] LD = 3'b000, INC = 3'b001, DEC = 3'b010, SHL = 3'b011;
  localparam logic [2:0] SHR = 3'b100, CLR = 3'b101, ADD = 3'b110, SUB = 3'b111;

  typedef struct {
    logic [1:0] sel;
    logic [2:0] op;
    logic [7:0] b;
    logic [7:0] val;
    logic       c;
    logic       z;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] val;
    logic       c;
    logic       z;
  } exp_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];
  exp_t sb [$];

  logic [7:0] mdl [4];
  logic       mdl_c, mdl_z;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one write on instance A, queue its expected outcome, then
  // compare once the sampling edge has passed.
  task automatic write_a(input logic [1:0] sel, input logic [2:0] o, input logic [7:0] b,
                         input logic [7:0] ev, input logic ec, input logic ez);
    exp_t e;
    @(negedge clk);
    a_n_load = 1'b0;
    a_wr_sel = sel;
    a_op     = o;
    a_bus_in = b;
    a_rd_sel = sel;
    e.sel = sel; e.val = ev; e.c = ec; e.z = ez;
    sb.push_back(e);
    @(posedge clk);
    #1;
    a_n_load = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("value_reg%0d", e.sel), {24'd0, a_value}, {24'd0, e.val});
      chk($sformatf("carry_reg%0d", e.sel), {31'd0, a_carry}, {31'd0, e.c});
      chk($sformatf("zero_reg%0d", e.sel),  {31'd0, a_zero},  {31'd0, e.z});
      mdl[e.sel] = e.val;
      mdl_c = e.c;
      mdl_z = e.z;
    end
  endtask

  task automatic write_b(input logic [1:0] sel, input logic [2:0] o, input logic [3:0] b);
    @(negedge clk);
    b_n_load = 1'b0;
    b_wr_sel = sel;
    b_op     = o;
    b_bus_in = b;
    @(posedge clk);
    #1;
    b_n_load = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{2'd0, LD,  8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, INC, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{2'd0, DEC, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{2'd3, LD,  8'h80, 8'h80, 1'b0, 1'b0};
    vecs[4]  = '{2'd3, ADD, 8'h90, 8'h10, 1'b1, 1'b0};
    vecs[5]  = '{2'd3, SUB, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[6]  = '{2'd3, SHR, 8'h00, 8'h78, 1'b0, 1'b0};
    vecs[7]  = '{2'd3, SHL, 8'h00, 8'hF0, 1'b0, 1'b0};
    vecs[8]  = '{2'd3, SHL, 8'h00, 8'hE0, 1'b1, 1'b0};
    vecs[9]  = '{2'd3, CLR, 8'hAA, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{2'd2, INC, 8'h00, 8'h01, 1'b0, 1'b0};
    vecs[11] = '{2'd2, INC, 8'h00, 8'h02, 1'b0, 1'b0};
    vecs[12] = '{2'd2, LD,  8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[13] = '{2'd1, LD,  8'h01, 8'h01, 1'b0, 1'b0};
    vecs[14] = '{2'd1, SHR, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[15] = '{2'd1, ADD, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[16] = '{2'd1, SUB, 8'h01, 8'hFF, 1'b1, 1'b0};

    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    mdl_c = 1'b0;
    mdl_z = 1'b0;

    rst_n    = 1'b0;
    a_n_load = 1'b1; a_wr_sel = 2'd0; a_op = LD; a_bus_in = 8'h00; a_n_out = 1'b1; a_rd_sel = 2'd0;
    b_n_load = 1'b1; b_wr_sel = 2'd0; b_op = LD; b_bus_in = 4'h0;  b_n_out = 1'b0; b_rd_sel = 2'd0;

    // Reset state
    #12;
    for (int s = 0; s < 4; s++) begin
      a_rd_sel = 2'(s);
      #1;
      chk($sformatf("reset_value_reg%0d", s), {24'd0, a_value}, 32'd0);
    end
    chk("reset_carry",   {31'd0, a_carry},  32'd0);
    chk("reset_zero",    {31'd0, a_zero},   32'd0);
    chk("reset_bus_out", {24'd0, a_bus_out}, 32'd0);
    chk("reset_bus_oe",  {31'd0, a_bus_oe},  32'd0);
    chk("reset_b_bus_oe", {31'd0, b_bus_oe}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of operations
    for (int i = 0; i < NVEC; i++) begin
      write_a(vecs[i].sel, vecs[i].op, vecs[i].b, vecs[i].val, vecs[i].c, vecs[i].z);
    end

    // Output gating: reg2 holds 0x3C
    @(negedge clk);
    a_rd_sel = 2'd2;
    a_n_out  = 1'b0;
    #1;
    chk("bus_out_enabled", {24'd0, a_bus_out}, 32'h3C);
    chk("bus_oe_enabled",  {31'd0, a_bus_oe},  32'd1);
    a_n_out = 1'b1;
    #1;
    chk("bus_out_disabled", {24'd0, a_bus_out}, 32'd0);
    chk("bus_oe_disabled",  {31'd0, a_bus_oe},  32'd0);
    chk("value_ungated",    {24'd0, a_value},   32'h3C);

    // Hold: strobe inactive while other inputs wander
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a_n_load = 1'b1;
      a_op     = 3'($urandom_range(0, 7));
      a_bus_in = 8'($urandom_range(0, 255));
      a_wr_sel = 2'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      a_rd_sel = 2'(s);
      #1;
      chk($sformatf("hold_value_reg%0d", s), {24'd0, a_value}, {24'd0, mdl[s]});
    end
    chk("hold_carry", {31'd0, a_carry}, {31'd0, mdl_c});
    chk("hold_zero",  {31'd0, a_zero},  {31'd0, mdl_z});

    // Read-during-write on reg1: old value before the edge, new after
    @(negedge clk);
    a_rd_sel = 2'd1;
    a_n_load = 1'b0;
    a_wr_sel = 2'd1;
    a_op     = LD;
    a_bus_in = 8'hA5;
    #1;
    chk("rdw_before_edge", {24'd0, a_value}, 32'hFF);
    @(posedge clk);
    #1;
    a_n_load = 1'b1;
    chk("rdw_after_edge", {24'd0, a_value}, 32'hA5);
    chk("rdw_carry",      {31'd0, a_carry}, 32'd0);
    mdl[1] = 8'hA5;

    // Asynchronous reset between edges, with a write pending
    write_a(2'd1, LD,  8'h50, 8'h50, 1'b0, 1'b0);
    write_a(2'd1, SUB, 8'hF6, 8'h5A, 1'b1, 1'b0);
    #1;
    rst_n    = 1'b0;
    a_n_load = 1'b0;
    a_wr_sel = 2'd1;
    a_op     = INC;
    #1;
    chk("async_rst_value_reg1", {24'd0, a_value}, 32'd0);
    chk("async_rst_carry",      {31'd0, a_carry}, 32'd0);
    chk("async_rst_zero",       {31'd0, a_zero},  32'd0);
    a_rd_sel = 2'd0;
    #1;
    chk("async_rst_value_reg0", {24'd0, a_value}, 32'd0);
    a_rd_sel = 2'd1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_n_load = 1'b1;
    chk("first_write_after_rst", {24'd0, a_value}, 32'h01);
    chk("first_write_carry",     {31'd0, a_carry}, 32'd0);
    chk("first_write_zero",      {31'd0, a_zero},  32'd0);

    // Instance B: unimplemented index 3
    write_b(2'd2, LD,  4'h9);
    write_b(2'd0, LD,  4'hF);
    write_b(2'd0, INC, 4'h0);
    b_rd_sel = 2'd0;
    #1;
    chk("b_inc_wrap_value", {28'd0, b_value}, 32'd0);
    chk("b_inc_wrap_carry", {31'd0, b_carry}, 32'd1);
    chk("b_inc_wrap_zero",  {31'd0, b_zero},  32'd1);
    write_b(2'd3, LD, 4'h5);
    chk("b_oob_carry_held", {31'd0, b_carry}, 32'd1);
    chk("b_oob_zero_held",  {31'd0, b_zero},  32'd1);
    for (int s = 0; s < 4; s++) begin
      b_rd_sel = 2'(s);
      #1;
      chk($sformatf("b_value_reg%0d", s), {28'd0, b_value}, (s == 2) ? 32'h9 : 32'h0);
    end
    b_rd_sel = 2'd3;
    #1;
    chk("b_oob_bus_out", {28'd0, b_bus_out}, 32'd0);

    if (sb.size() != 0) chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_reg_bank
`default_nettype wire
